contador_comando: RTL and testbench
===================================

Name: contador_comando

Overview:
Command-side driver for the team's 8-bit up/down counter, which takes one-cycle increment/decrement strobes and resets to 106. It accepts a target value over a valid/ready handshake and emits acrescer/decrecer strobes, one step at a time, until the counter reaches the target. It keeps a shadow copy of the counter, so it needs no feedback path. It sits between control logic and the counter and shares the counter's clk/rst_n.

Parameters:
WIDTH, 8, counter width; all values are modulo 2^WIDTH
RESET_VALUE, 106, shadow value after reset; must equal the counter's reset value
GAP_CYCLES, 0, number of idle (both strobes low) cycles inserted after every strobe
SHORTEST_PATH, 1, 1 = choose the shorter direction around the ring; 0 = always count up

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
alvo_valid  input  1  target request valid
alvo_ready  output  1  block can accept a target (IDLE only)
alvo  input  WIDTH  target value, sampled at handshake
cancelar  input  1  abort the current move
acrescer  output  1  increment strobe to the counter
decrecer  output  1  decrement strobe to the counter
ocupado  output  1  a move is in progress
concluido  output  1  one-cycle pulse: target reached
espelho  output  WIDTH  shadow count; equals the counter value at all times

Behaviour:
- Reset (async): state=IDLE, espelho=RESET_VALUE, acrescer=decrecer=0, concluido=0, ocupado=0, alvo_ready=1.
- States: IDLE, PULSE, GAP, DONE.
- All outputs come directly from flops or from the state register. No combinational path from any input to any output.
- acrescer and decrecer are never high in the same cycle.
- IDLE:
  - alvo_ready=1.
  - On an edge with alvo_valid=1: latch the target and compute diff = (alvo - espelho) mod 2^WIDTH.
  - diff==0: go to DONE (no strobes).
  - diff!=0: go to PULSE and latch dir and remaining steps.
- Direction and step count:
  - SHORTEST_PATH=1: diff <= 2^(WIDTH-1) means up, with steps=diff. Otherwise down, with steps=2^WIDTH - diff.
  - Tie (diff=128 at WIDTH=8) resolves to up.
  - SHORTEST_PATH=0: always up, steps=diff.
- PULSE:
  - Exactly one strobe (acrescer if up, decrecer if down) is high for this cycle.
  - At the closing edge: espelho ±1 (wrapping mod 2^WIDTH), steps decrements.
  - If steps reaches 0: go to DONE.
  - Else go to GAP if GAP_CYCLES>0, else stay in PULSE (back-to-back strobes).
- GAP: both strobes low for GAP_CYCLES cycles, then PULSE.
- DONE: concluido=1 and alvo_ready=0 for exactly one cycle, then IDLE.
- ocupado=1 in PULSE, GAP and DONE.
- Latency: the handshake happens at edge N; the first strobe is visible in cycle N..N+1. A move of d steps with gap g produces concluido in cycle d + (d-1)·g + 1 after the handshake.
- Wrap-around is allowed in both directions (255→0 and 0→255).
- alvo_valid outside IDLE is ignored; no target is queued.
- cancelar:
  - Sampled in PULSE or GAP.
  - The strobe in the current PULSE cycle still completes, so espelho stays consistent.
  - The next state is IDLE. No concluido pulse is produced.
  - cancelar is ignored in IDLE and DONE.
  - If cancelar and the final step coincide, the final step takes precedence: go to DONE.
- Reset mid-move: immediate return to the reset values. The counter resets on the same rst_n, so espelho stays aligned with it.

Decomposition:
- Package contador_pkg holds:
  - the state enum {IDLE, PULSE, GAP, DONE};
  - the RESET_VALUE default (106), shared with the counter;
  - a direction typedef {UP, DOWN}.
- One sub-module is natural: contador_dist, a purely combinational block.
  - Inputs: espelho, alvo, SHORTEST_PATH.
  - Outputs: dir and steps (WIDTH bits).
  - The FSM, gap counter and shadow register stay in the top module.

Test Plan:
- Reset release -> espelho=106, alvo_ready=1, both strobes 0. Target 110 -> 4 consecutive acrescer cycles, concluido in the 5th cycle, espelho=110, and the attached counter reads 110.
- From 106, target 100 -> 6 decrecer cycles, no acrescer, concluido, espelho=100.
- From 250, target 4 -> 10 acrescer cycles wrapping 255→0, espelho=4. From 0, target 128 -> 128 acrescer (tie goes up). With SHORTEST_PATH=0, 106→100 -> 250 acrescer.
- Target equal to espelho -> no strobes, concluido in the cycle after the handshake. alvo_valid held during DONE -> not accepted until IDLE.
- GAP_CYCLES=2, 106→108 -> strobe pattern acrescer 1,0,0,1, then concluido; total 5 cycles.
- Mid-move checks:
  - cancelar after 3 of 10 steps -> espelho=start+3, no concluido, alvo_ready=1.
  - rst_n pulse mid-move -> espelho=106, strobes drop immediately, counter=106.

Source files
------------

// File: rtl/contador_pkg.sv
// Shared types for the counter command driver.
// The reset value here must match the counter's own reset value.
package contador_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP,
    DONE
  } estado_t;

  typedef enum logic {
    UP,
    DOWN
  } dir_t;

  localparam int RESET_VALUE_DEF = 106;

endpackage

// File: rtl/contador_dist.sv
// Ring distance from the shadow count to a target.
// Picks the step direction and the number of steps to take.
module contador_dist
  import contador_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int SHORTEST_PATH = 1
) (
  input  logic [WIDTH-1:0] espelho,
  input  logic [WIDTH-1:0] alvo,
  output dir_t             dir,
  output logic [WIDTH-1:0] steps
);

  localparam logic [WIDTH-1:0] HALF =
    WIDTH'(1) << (WIDTH - 1);

  logic [WIDTH-1:0] diff;

  // A tie at exactly half the ring goes up
  always_comb begin
    diff  = alvo - espelho;
    dir   = UP;
    steps = diff;
    if (SHORTEST_PATH != 0 && diff > HALF) begin
      dir   = DOWN;
      steps = WIDTH'(0) - diff;
    end
  end

endmodule

// File: rtl/contador_comando.sv
// Command-side driver: walks an up/down counter to a target
// with one-cycle strobes while tracking a shadow copy of it.
module contador_comando
  import contador_pkg::*;
#(
  parameter int WIDTH         = 8,
  parameter int RESET_VALUE   = RESET_VALUE_DEF,
  parameter int GAP_CYCLES    = 0,
  parameter int SHORTEST_PATH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alvo_valid,
  output logic             alvo_ready,
  input  logic [WIDTH-1:0] alvo,
  input  logic             cancelar,
  output logic             acrescer,
  output logic             decrecer,
  output logic             ocupado,
  output logic             concluido,
  output logic [WIDTH-1:0] espelho
);

  localparam int GW =
    (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  estado_t          estado_q, estado_d;
  dir_t             dir_q, dir_d;
  logic [WIDTH-1:0] steps_q, steps_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [WIDTH-1:0] espelho_q, espelho_d;

  dir_t             dist_dir;
  logic [WIDTH-1:0] dist_steps;

  contador_dist #(
    .WIDTH         (WIDTH),
    .SHORTEST_PATH (SHORTEST_PATH)
  ) u_dist (
    .espelho (espelho_q),
    .alvo    (alvo),
    .dir     (dist_dir),
    .steps   (dist_steps)
  );

  always_comb begin
    estado_d  = estado_q;
    dir_d     = dir_q;
    steps_d   = steps_q;
    gap_d     = gap_q;
    espelho_d = espelho_q;
    unique case (estado_q)
      IDLE: begin
        if (alvo_valid) begin
          dir_d    = dist_dir;
          steps_d  = dist_steps;
          estado_d = (dist_steps == '0) ? DONE : PULSE;
        end
      end
      PULSE: begin
        // The strobe always lands, even when cancelled
        espelho_d = (dir_q == UP) ? espelho_q + 1'b1
                                  : espelho_q - 1'b1;
        steps_d   = steps_q - 1'b1;
        if (steps_q == WIDTH'(1)) begin
          estado_d = DONE;
        end else if (cancelar) begin
          estado_d = IDLE;
        end else if (GAP_CYCLES > 0) begin
          estado_d = GAP;
          gap_d    = GW'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (cancelar) begin
          estado_d = IDLE;
        end else if (gap_q == '0) begin
          estado_d = PULSE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      DONE: begin
        estado_d = IDLE;
      end
      default: begin
        estado_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= IDLE;
      dir_q     <= UP;
      steps_q   <= '0;
      gap_q     <= '0;
      espelho_q <= WIDTH'(RESET_VALUE);
    end else begin
      estado_q  <= estado_d;
      dir_q     <= dir_d;
      steps_q   <= steps_d;
      gap_q     <= gap_d;
      espelho_q <= espelho_d;
    end
  end

  assign alvo_ready = (estado_q == IDLE);
  assign ocupado    = (estado_q != IDLE);
  assign concluido  = (estado_q == DONE);
  assign acrescer   = (estado_q == PULSE) && (dir_q == UP);
  assign decrecer   = (estado_q == PULSE) && (dir_q == DOWN);
  assign espelho    = espelho_q;

endmodule

// File: tb/tb_contador_comando.sv
// Bench for contador_comando: three configurations against a
// schedule-based reference model plus an attached counter.
module tb_contador_comando;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]       av, cn, rdy, acr, dec, ocu, con;
  logic [2:0][7:0]  al, esp, ctr;

  contador_comando u0 (
    .clk(clk), .rst_n(rst_n),
    .alvo_valid(av[0]), .alvo_ready(rdy[0]),
    .alvo(al[0]), .cancelar(cn[0]),
    .acrescer(acr[0]), .decrecer(dec[0]),
    .ocupado(ocu[0]), .concluido(con[0]),
    .espelho(esp[0])
  );

  contador_comando #(.SHORTEST_PATH(0)) u1 (
    .clk(clk), .rst_n(rst_n),
    .alvo_valid(av[1]), .alvo_ready(rdy[1]),
    .alvo(al[1]), .cancelar(cn[1]),
    .acrescer(acr[1]), .decrecer(dec[1]),
    .ocupado(ocu[1]), .concluido(con[1]),
    .espelho(esp[1])
  );

  contador_comando #(.GAP_CYCLES(2)) u2 (
    .clk(clk), .rst_n(rst_n),
    .alvo_valid(av[2]), .alvo_ready(rdy[2]),
    .alvo(al[2]), .cancelar(cn[2]),
    .acrescer(acr[2]), .decrecer(dec[2]),
    .ocupado(ocu[2]), .concluido(con[2]),
    .espelho(esp[2])
  );

  // Independent up/down counter driven by the strobes
  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) ctr[i] <= 8'd106;
      else if (acr[i]) ctr[i] <= ctr[i] + 8'd1;
      else if (dec[i]) ctr[i] <= ctr[i] - 8'd1;
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int g_p  [3] = '{0, 0, 2};
  int sp_p [3] = '{1, 0, 1};

  // Model: a move is a schedule of cycles k = 0..last.
  bit m_busy [3];
  bit m_up   [3];
  int m_d    [3];
  int m_k    [3];
  int m_cnt  [3];
  int hs_cyc [3];

  int n_a [3];
  int n_d [3];
  int n_c [3];
  int done_at [3];
  logic [15:0] pat [3];

  function automatic int last_k(int i);
    if (m_d[i] == 0) return 0;
    return m_d[i] + (m_d[i] - 1) * g_p[i];
  endfunction

  // 0 = idle gap cycle, 1 = strobe, 2 = done
  function automatic int kind(int i);
    if (m_k[i] == last_k(i)) return 2;
    if (m_k[i] % (g_p[i] + 1) == 0) return 1;
    return 0;
  endfunction

  task automatic chk(string nm, int i, int got, int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s[%0d] cyc=%0d got=%0d exp=%0d",
               nm, i, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_busy[i] = 1'b0;
      m_cnt[i]  = 106;
      m_k[i]    = 0;
      m_d[i]    = 0;
    end
  endtask

  task automatic model_edge();
    int diff, kd;
    for (int i = 0; i < 3; i++) begin
      if (!m_busy[i]) begin
        if (av[i]) begin
          diff = (int'(al[i]) - m_cnt[i] + 256) % 256;
          if (sp_p[i] != 0 && diff > 128) begin
            m_up[i] = 1'b0;
            m_d[i]  = 256 - diff;
          end else begin
            m_up[i] = 1'b1;
            m_d[i]  = diff;
          end
          m_busy[i] = 1'b1;
          m_k[i]    = 0;
          hs_cyc[i] = cyc;
        end
      end else begin
        kd = kind(i);
        if (kd == 1)
          m_cnt[i] = (m_cnt[i] + (m_up[i] ? 1 : 255)) % 256;
        if (kd == 2)
          m_busy[i] = 1'b0;
        else if (cn[i] &&
                 !(kd == 1 &&
                   m_k[i] == (m_d[i] - 1) * (g_p[i] + 1)))
          m_busy[i] = 1'b0;
        else
          m_k[i]++;
      end
    end
  endtask

  task automatic compare();
    int kd;
    for (int i = 0; i < 3; i++) begin
      kd = m_busy[i] ? kind(i) : -1;
      chk("ready", i, int'(rdy[i]), int'(!m_busy[i]));
      chk("ocupado", i, int'(ocu[i]), int'(m_busy[i]));
      chk("acrescer", i, int'(acr[i]),
          int'(kd == 1 && m_up[i]));
      chk("decrecer", i, int'(dec[i]),
          int'(kd == 1 && !m_up[i]));
      chk("concluido", i, int'(con[i]), int'(kd == 2));
      chk("espelho", i, int'(esp[i]), m_cnt[i]);
      chk("counter", i, int'(ctr[i]), int'(esp[i]));
      chk("both_strobes", i, int'(acr[i] & dec[i]), 0);
      if (acr[i]) n_a[i]++;
      if (dec[i]) n_d[i]++;
      if (con[i]) begin
        n_c[i]++;
        done_at[i] = cyc - hs_cyc[i];
      end
      pat[i] = {pat[i][14:0], acr[i]};
    end
  endtask

  task automatic step();
    model_edge();
    @(negedge clk);
    cyc++;
    compare();
  endtask

  task automatic clr_obs(int i);
    n_a[i] = 0;
    n_d[i] = 0;
    n_c[i] = 0;
    done_at[i] = -1;
    pat[i] = '0;
  endtask

  task automatic wait_idle(int i, int cancel_n);
    for (int b = 0; b < 2000 && m_busy[i]; b++) begin
      cn[i] = (cancel_n > 0 && (n_a[i] + n_d[i]) == cancel_n
               && (acr[i] | dec[i]));
      step();
    end
    cn[i] = 1'b0;
    if (m_busy[i]) begin
      total++;
      bad++;
      $display("FAIL timeout[%0d] cyc=%0d busy=1 want=0", i, cyc);
    end
  endtask

  task automatic move(int i, int t, int cancel_n);
    clr_obs(i);
    al[i] = 8'(t);
    av[i] = 1'b1;
    step();
    av[i] = 1'b0;
    wait_idle(i, cancel_n);
  endtask

  initial begin
    rst_n = 1'b0;
    av = '0;
    cn = '0;
    al = '0;
    model_reset();
    for (int i = 0; i < 3; i++) clr_obs(i);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare();
    chk("rst_espelho", 0, int'(esp[0]), 106);
    chk("rst_ready", 0, int'(rdy[0]), 1);

    move(0, 110, 0);
    chk("up4_n", 0, n_a[0], 4);
    chk("up4_done_at", 0, done_at[0], 5);
    chk("up4_esp", 0, int'(esp[0]), 110);
    chk("up4_ctr", 0, int'(ctr[0]), 110);

    move(0, 100, 0);
    chk("dn_n", 0, n_d[0], 10);
    chk("dn_na", 0, n_a[0], 0);
    chk("dn_esp", 0, int'(esp[0]), 100);

    move(0, 106, 0);
    move(0, 100, 0);
    chk("dn6_n", 0, n_d[0], 6);
    chk("dn6_c", 0, n_c[0], 1);

    move(0, 250, 0);
    move(0, 4, 0);
    chk("wrap_n", 0, n_a[0], 10);
    chk("wrap_esp", 0, int'(esp[0]), 4);

    move(0, 0, 0);
    chk("wrapdn_n", 0, n_d[0], 4);
    move(0, 128, 0);
    chk("tie_n", 0, n_a[0], 128);
    chk("tie_nd", 0, n_d[0], 0);

    // Equal target, then valid held through DONE
    clr_obs(0);
    al[0] = 8'd128;
    av[0] = 1'b1;
    step();
    chk("eq_done", 0, int'(con[0]), 1);
    chk("eq_ready", 0, int'(rdy[0]), 0);
    chk("eq_done_at", 0, done_at[0], 1);
    al[0] = 8'd130;
    step();
    chk("held_ready", 0, int'(rdy[0]), 1);
    chk("held_esp", 0, int'(esp[0]), 128);
    step();
    av[0] = 1'b0;
    wait_idle(0, 0);
    chk("held_esp2", 0, int'(esp[0]), 130);

    move(0, 140, 3);
    chk("cancel_esp", 0, int'(esp[0]), 133);
    chk("cancel_nc", 0, n_c[0], 0);
    chk("cancel_rdy", 0, int'(rdy[0]), 1);

    move(1, 100, 0);
    chk("nosp_n", 1, n_a[1], 250);
    chk("nosp_esp", 1, int'(esp[1]), 100);

    move(2, 108, 0);
    chk("gap_pat", 2, int'(pat[2][5:0]), 6'b100100);
    chk("gap_done_at", 2, done_at[2], 5);
    chk("gap_esp", 2, int'(esp[2]), 108);

    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < 3; i++) begin
        if (!m_busy[i] && $urandom_range(3) == 0) begin
          av[i] = 1'b1;
          al[i] = ($urandom_range(7) == 0) ? 8'(m_cnt[i])
                                            : 8'($urandom);
        end else begin
          av[i] = ($urandom_range(7) == 0);
          al[i] = 8'($urandom);
        end
        cn[i] = ($urandom_range(15) == 0);
      end
      step();
    end
    av = '0;
    cn = '0;
    for (int i = 0; i < 3; i++) wait_idle(i, 0);

    // Reset in the middle of a move
    for (int i = 0; i < 3; i++) begin
      av[i] = 1'b1;
      al[i] = 8'(m_cnt[i] + 50);
    end
    step();
    av = '0;
    repeat (3) step();
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_acr", i, int'(acr[i]), 0);
      chk("rstmid_esp", i, int'(esp[i]), 106);
      chk("rstmid_ctr", i, int'(ctr[i]), 106);
      chk("rstmid_rdy", i, int'(rdy[i]), 1);
    end
    model_reset();
    #1 rst_n = 1'b1;
    repeat (4) step();
    move(0, 107, 0);
    chk("post_rst_n", 0, n_a[0], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
